// File: rtl/inc_counter_nbit_if.sv
// Control and status bundle for inc_counter_nbit.
// master drives the controls and observes the count; slave is the counter.
interface inc_counter_nbit_if #(
  parameter int WIDTH = 16
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             clr_ovf;
  logic             sat;
  logic [WIDTH-1:0] q;
  logic             co;
  logic             ovf;
  logic             zero;

  modport master (
    output en, up, load, d, clr_ovf, sat,
    input  q, co, ovf, zero
  );

  modport slave (
    input  en, up, load, d, clr_ovf, sat,
    output q, co, ovf, zero
  );
endinterface

// File: rtl/inc_counter_nbit.sv
// Up/down counter modulo MAX_VAL+1 with load, carry/borrow pulse and sticky overflow.
// Define COUNTER_SAT_EN to let bus.sat hold q at the terminal value instead of wrapping.
module inc_counter_nbit #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input logic               clk,
  input logic               rst,
  inc_counter_nbit_if.slave bus
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic             wrap;
  logic             sat_hold;

`ifdef COUNTER_SAT_EN
  assign sat_hold = bus.sat;
`else
  // sat is kept on the port for a uniform interface but has no effect here
  assign sat_hold = bus.sat & 1'b0;
`endif

  always_comb begin
    q_d  = q_q;
    wrap = 1'b0;
    if (bus.load) begin
      q_d = (bus.d > MAX_VAL) ? MAX_VAL : bus.d;
    end else if (bus.en) begin
      if (bus.up) begin
        if (q_q >= MAX_VAL) begin
          wrap = 1'b1;
          q_d  = sat_hold ? MAX_VAL : '0;
        end else begin
          q_d = q_q + 1'b1;
        end
      end else begin
        if (q_q == '0) begin
          wrap = 1'b1;
          q_d  = sat_hold ? '0 : MAX_VAL;
        end else begin
          q_d = q_q - 1'b1;
        end
      end
    end
    co_d  = wrap;
    // a wrap in the same cycle as clr_ovf keeps the flag set
    ovf_d = wrap | (ovf_q & ~bus.clr_ovf);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= '0;
      co_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      co_q  <= co_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.co   = co_q;
  assign bus.ovf  = ovf_q;
  assign bus.zero = (q_q == '0);

endmodule

// File: tb/tb_inc_counter_nbit.sv
// Directed bench for inc_counter_nbit: a full-width instance driven from a vector
// table plus a MAX_VAL=9 instance for modulus and load-clamp corners.
module tb_inc_counter_nbit;

`ifdef COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk;
  logic rst16, rst4;
  int   n_cmp, n_bad;

  inc_counter_nbit_if #(.WIDTH(16)) b16 ();
  inc_counter_nbit_if #(.WIDTH(4))  b4 ();

  inc_counter_nbit #(.WIDTH(16)) dut16 (
    .clk (clk),
    .rst (rst16),
    .bus (b16)
  );

  inc_counter_nbit #(.WIDTH(4), .MAX_VAL(4'd9)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (b4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst, load, en, up, clr, sat;
    logic [15:0] d;
    logic [15:0] eq;
    logic        eco, eovf, ez;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, ld, e, u, c, s, input logic [15:0] dv,
                     input logic [15:0] xq, input logic xco, xovf, xz);
    vec_t v;
    v.rst = r; v.load = ld; v.en = e; v.up = u; v.clr = c; v.sat = s;
    v.d = dv; v.eq = xq; v.eco = xco; v.eovf = xovf; v.ez = xz;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive16(input logic ld, e, u, c, s, input logic [15:0] dv);
    b16.load = ld; b16.en = e; b16.up = u; b16.clr_ovf = c; b16.sat = s; b16.d = dv;
  endtask

  task automatic drive4(input logic ld, e, u, input logic [3:0] dv);
    b4.load = ld; b4.en = e; b4.up = u; b4.clr_ovf = 1'b0; b4.sat = 1'b0; b4.d = dv;
  endtask

  task automatic chk4(input string nm, input logic [3:0] xq, input logic xco, xovf);
    chk({nm, " q"},   b4.q,   xq);
    chk({nm, " co"},  b4.co,  xco);
    chk({nm, " ovf"}, b4.ovf, xovf);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst4  = 1'b1;
    rst16 = 1'b1;
    drive16(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    drive4(1'b0, 1'b0, 1'b0, 4'h0);

    //   rst ld en up clr sat d        q                co   ovf  zero
    add(1, 1, 1, 1, 0, 0, 16'h1234, 16'h0000,         0,   0,   1);
    add(1, 1, 1, 1, 0, 0, 16'h1234, 16'h0000,         0,   0,   1);
    add(0, 1, 0, 0, 0, 0, 16'hFFFE, 16'hFFFE,         0,   0,   0);
    add(0, 0, 1, 1, 0, 0, 16'h0000, 16'hFFFF,         0,   0,   0);
    add(0, 0, 1, 1, 0, 0, 16'h0000, 16'h0000,         1,   1,   1);
    add(0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000,         0,   1,   1);
    add(0, 0, 0, 1, 1, 0, 16'h0000, 16'h0000,         0,   0,   1);
    add(0, 0, 1, 0, 0, 0, 16'h0000, 16'hFFFF,         1,   1,   0);
    add(0, 0, 1, 0, 0, 0, 16'h0000, 16'hFFFE,         0,   1,   0);
    add(0, 0, 1, 1, 1, 0, 16'h0000, 16'hFFFF,         0,   0,   0);
    add(0, 0, 1, 1, 1, 0, 16'h0000, 16'h0000,         1,   1,   1);
    add(0, 1, 1, 1, 0, 0, 16'h0007, 16'h0007,         0,   1,   0);
    add(0, 1, 0, 0, 0, 0, 16'd122,  16'd122,          0,   1,   0);
    add(0, 0, 1, 1, 0, 0, 16'h0000, 16'd123,          0,   1,   0);
    add(1, 0, 1, 1, 0, 0, 16'h0000, 16'h0000,         0,   0,   1);
    add(0, 1, 0, 0, 0, 0, 16'hFFFF, 16'hFFFF,         0,   0,   0);
    add(0, 0, 1, 1, 0, 1, 16'h0000, SAT ? 16'hFFFF : 16'h0000, 1, 1, SAT ? 1'b0 : 1'b1);
    add(0, 0, 1, 1, 0, 0, 16'h0000, SAT ? 16'h0000 : 16'h0001, SAT ? 1'b1 : 1'b0, 1, SAT ? 1'b1 : 1'b0);
    add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000,         0,   0,   1);
    add(0, 0, 1, 0, 0, 1, 16'h0000, SAT ? 16'h0000 : 16'hFFFF, 1, 1, SAT ? 1'b1 : 1'b0);

    foreach (tbl[i]) begin
      rst16 = tbl[i].rst;
      drive16(tbl[i].load, tbl[i].en, tbl[i].up, tbl[i].clr, tbl[i].sat, tbl[i].d);
      tick();
      chk($sformatf("row%0d q", i),    b16.q,    tbl[i].eq);
      chk($sformatf("row%0d co", i),   b16.co,   tbl[i].eco);
      chk($sformatf("row%0d ovf", i),  b16.ovf,  tbl[i].eovf);
      chk($sformatf("row%0d zero", i), b16.zero, tbl[i].ez);
    end

    // steady count from 5000 for 30 cycles, no carry
    rst16 = 1'b0;
    drive16(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd5000);
    tick();
    chk("run load q", b16.q, 16'd5000);
    drive16(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk($sformatf("run%0d q", k),  b16.q,  16'd5000 + k[15:0]);
      chk($sformatf("run%0d co", k), b16.co, 1'b0);
    end
    chk("run ovf", b16.ovf, 1'b0);
    drive16(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

    // modulus 10 instance: borrow to 9, load clamp, carry from 9
    tick();
    chk4("m9 rst", 4'd0, 1'b0, 1'b0);
    chk("m9 rst zero", b4.zero, 1'b1);
    rst4 = 1'b0;
    drive4(1'b0, 1'b1, 1'b0, 4'd0);
    tick();
    chk4("m9 down", 4'd9, 1'b1, 1'b1);
    drive4(1'b1, 1'b0, 1'b0, 4'd12);
    tick();
    chk4("m9 clamp12", 4'd9, 1'b0, 1'b1);
    drive4(1'b1, 1'b0, 1'b0, 4'd15);
    tick();
    chk4("m9 clamp15", 4'd9, 1'b0, 1'b1);
    drive4(1'b0, 1'b1, 1'b1, 4'd0);
    tick();
    chk4("m9 up wrap", 4'd0, 1'b1, 1'b1);
    tick();
    chk4("m9 up one", 4'd1, 1'b0, 1'b1);
    drive4(1'b1, 1'b1, 1'b0, 4'd3);
    tick();
    chk4("m9 load3", 4'd3, 1'b0, 1'b1);
    drive4(1'b0, 1'b1, 1'b0, 4'd0);
    tick();
    chk4("m9 down2", 4'd2, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
